// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared encodings and helpers for the MEM stage
// Rev 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } stage_e;

    // Ceiling log2, floored at 1 so derived vectors never collapse to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ld_align.sv
`default_nettype none
// ============================================================================
// ld_align : combinational load-lane extractor with sign/zero extension
// Rev 1.0
// ============================================================================
module ld_align
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [OFF_W-1:0]  addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [OFF_W-1:0] H_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] W_MASK = ~OFF_W'(3);

    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      lane_w;

    // Wider accesses ignore the low offset bits instead of faulting.
    assign off_h  = addr_lo_i & H_MASK;
    assign off_w  = addr_lo_i & W_MASK;
    assign lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_h = rdata_i[{off_h, 3'b000} +: 16];
    assign lane_w = rdata_i[{off_w, 3'b000} +: 32];

    always_comb begin
        data_o = rdata_i;
        case (ld_size_e'(size_i))
            LD_B:    data_o = unsigned_i ? DATA_W'(lane_b) : DATA_W'(signed'(lane_b));
            LD_H:    data_o = unsigned_i ? DATA_W'(lane_h) : DATA_W'(signed'(lane_h));
            LD_W:    data_o = unsigned_i ? DATA_W'(lane_w) : DATA_W'(signed'(lane_w));
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ls.sv
`default_nettype none
// ============================================================================
// mem_stage_ls : MEM pipeline stage with data-SRAM wait and flush discard
// Rev 1.0
// ============================================================================
module mem_stage_ls
    import mem_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int PC_W    = 32,
    parameter  int RF_AW   = 5,
    parameter  int MAX_OUT = 2,
    localparam int OFF_W   = clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_to_mem_valid,
    output logic              mem_allowin,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_rf_we,
    input  logic [RF_AW-1:0]  in_rf_waddr,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_req_issued,
    input  logic              in_res_from_mem,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [OFF_W-1:0]  in_addr_lo,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              mem_to_wb_valid,
    input  logic              wb_allowin,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_rf_we,
    output logic [RF_AW-1:0]  out_rf_waddr,
    output logic [DATA_W-1:0] out_rf_wdata,
    output logic              fwd_we,
    output logic [RF_AW-1:0]  fwd_waddr,
    output logic [DATA_W-1:0] fwd_wdata,
    output logic              fwd_pending
);

    localparam int             CNT_W   = clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    stage_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    pc_q;
    logic               rf_we_q;
    logic [RF_AW-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]  alu_q;
    logic               res_mem_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [OFF_W-1:0]   addr_lo_q;
    logic [DATA_W-1:0]  rdata_q;

    logic               in_fire;
    logic               discard;
    logic               killed_owed;
    logic               capture;
    logic [DATA_W-1:0]  ld_data;
    logic [DATA_W-1:0]  wdata;

    always_comb begin
        in_fire     = ex_to_mem_valid & mem_allowin & ~flush;
        discard     = data_sram_data_ok & (cnt_q != '0);
        killed_owed = flush & (state_q == ST_WAIT);
        capture     = (state_q == ST_WAIT) & data_sram_data_ok & ~discard & ~flush;

        // A response arriving with the kill belongs to the oldest owed request,
        // so the count stays level: one consumed, one newly orphaned.
        cnt_d = cnt_q;
        if (killed_owed) begin
            if (!data_sram_data_ok && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (discard) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (in_fire) begin
            state_d = in_req_issued ? ST_WAIT : ST_READY;
        end else if (capture) begin
            state_d = ST_READY;
        end else if ((state_q == ST_READY) && wb_allowin) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            cnt_q      <= '0;
            pc_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            alu_q      <= '0;
            res_mem_q  <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            addr_lo_q  <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_fire) begin
                pc_q       <= in_pc;
                rf_we_q    <= in_rf_we;
                rf_waddr_q <= in_rf_waddr;
                alu_q      <= in_alu_result;
                res_mem_q  <= in_res_from_mem;
                size_q     <= in_ld_size;
                uns_q      <= in_ld_unsigned;
                addr_lo_q  <= in_addr_lo;
            end
            if (capture) begin
                rdata_q <= data_sram_rdata;
            end
        end
    end

    ld_align #(
        .DATA_W (DATA_W)
    ) u_ld_align (
        .rdata_i    (rdata_q),
        .addr_lo_i  (addr_lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    assign wdata           = res_mem_q ? ld_data : alu_q;
    assign mem_allowin     = (state_q == ST_EMPTY) | ((state_q == ST_READY) & wb_allowin);
    assign mem_to_wb_valid = (state_q == ST_READY);
    assign out_pc          = pc_q;
    assign out_rf_we       = rf_we_q & mem_to_wb_valid;
    assign out_rf_waddr    = rf_waddr_q;
    assign out_rf_wdata    = wdata;
    assign fwd_we          = rf_we_q & (state_q != ST_EMPTY);
    assign fwd_waddr       = rf_waddr_q;
    assign fwd_wdata       = wdata;
    assign fwd_pending     = fwd_we & (state_q == ST_WAIT);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(data_sram_data_ok && (cnt_q == '0) && (state_q != ST_WAIT)))
                else $error("mem_stage_ls: data_ok with no owed response");
            assert (!(killed_owed && !data_sram_data_ok && (cnt_q == CNT_MAX)))
                else $error("mem_stage_ls: discard counter overflow");
        end
    end
`endif

endmodule
`default_nettype wire
